// File: rtl/tt_readback_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table readback sweeper.
package tt_readback_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int N_IN_DEFAULT          = 3;
    localparam int SETTLE_CYCLES_DEFAULT = 4;
    localparam int SAMPLES_DEFAULT       = 3;

    // Truth-table code width for a given number of logic inputs.
    function automatic int code_w(input int n_in);
        return 2 ** n_in;
    endfunction

    // Bits needed for a counter that runs 0..max_count-1 (never narrower than 1).
    function automatic int cnt_w(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/tt_readback_sweeper_if.sv
// Control, stimulus and result bundle of the readback sweeper.
// Optional TT_READBACK_EXPECT_EN adds expected_code / mismatch.
interface tt_readback_sweeper_if #(
    parameter int N_IN = 3
);
    import tt_readback_pkg::*;

    localparam int CODE_W = code_w(N_IN);

    logic              start;
    logic [N_IN-1:0]   drive_in;
    logic              dut_out;
    logic              busy;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
`ifdef TT_READBACK_EXPECT_EN
    logic [CODE_W-1:0] expected_code;
    logic              mismatch;
`endif

    // Harness side: requests sweeps, models the logic-under-test, consumes codes.
    modport master (
        output start, dut_out, code_ready,
        input  drive_in, busy, code, code_valid
`ifdef TT_READBACK_EXPECT_EN
        , output expected_code,
        input  mismatch
`endif
    );

    // Sweeper side.
    modport slave (
        input  start, dut_out, code_ready,
        output drive_in, busy, code, code_valid
`ifdef TT_READBACK_EXPECT_EN
        , input expected_code,
        output mismatch
`endif
    );

endinterface

// File: rtl/tt_readback_sweeper_sampler.sv
// Majority voter: counts ones over SAMPLES enabled cycles and strobes the voted
// bit combinationally on the last of them.
module tt_majority_sampler
    import tt_readback_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic bit_valid,
    output logic bit_val
);

    localparam int IDX_W  = cnt_w(SAMPLES);
    localparam int ONES_W = cnt_w(SAMPLES + 1);

    logic [IDX_W-1:0]  idx_q;
    logic [ONES_W-1:0] ones_q;
    logic [ONES_W-1:0] ones_total;
    logic              last;

    assign last       = (idx_q == IDX_W'(SAMPLES - 1));
    assign ones_total = ones_q + ONES_W'(din);
    assign bit_valid  = en && last;
    assign bit_val    = (ones_total > ONES_W'(SAMPLES / 2));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ones_q <= '0;
        end else if (en) begin
            if (last) begin
                idx_q  <= '0;
                ones_q <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                ones_q <= ones_total;
            end
        end
    end

endmodule

// File: rtl/tt_readback_sweeper.sv
// Sweeps every input vector through a logic-under-test and rebuilds its truth-table
// code. Optional TT_READBACK_EXPECT_EN compares the result to an expected code.
module tt_readback_sweeper
    import tt_readback_pkg::*;
#(
    parameter int N_IN          = N_IN_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int SAMPLES       = SAMPLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_readback_sweeper_if.slave bus
);

    localparam int              CODE_W   = code_w(N_IN);
    localparam int              SETTLE_W = cnt_w(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [N_IN-1:0]     vec_q;
    logic [CODE_W-1:0]   code_q;
    logic                accept;
    logic                sample_en;
    logic                settle_last;
    logic                last_vec;
    logic                bit_valid;
    logic                bit_val;

    assign settle_last = (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));
    assign last_vec    = (vec_q == LAST_VEC);

    tt_majority_sampler #(
        .SAMPLES (SAMPLES)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sample_en),
        .din       (bus.dut_out),
        .bit_valid (bit_valid),
        .bit_val   (bit_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) state_d = SAMPLE;
            end
            SAMPLE: begin
                sample_en = 1'b1;
                if (bit_valid) state_d = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                if (bus.code_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: code_q is a plain register, not a memory, so it takes the async reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_q <= '0;
            vec_q        <= '0;
            code_q       <= '0;
        end else begin
            if (state_q == SETTLE && !settle_last) settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
            else                                   settle_cnt_q <= '0;

            if (accept) begin
                vec_q  <= '0;
                code_q <= '0;
            end else if (bit_valid) begin
                // Vector i lands at bit CODE_W-1-i, which for CODE_W = 2**N_IN is simply ~i.
                code_q[~vec_q] <= bit_val;
                if (!last_vec) vec_q <= vec_q + N_IN'(1);
            end
        end
    end

    assign bus.drive_in   = vec_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.code       = code_q;
    assign bus.code_valid = (state_q == DONE);

`ifdef TT_READBACK_EXPECT_EN
    logic [CODE_W-1:0] expected_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      expected_q <= '0;
        else if (accept) expected_q <= bus.expected_code;
    end

    assign bus.mismatch = (state_q == DONE) && (code_q != expected_q);
`endif

endmodule
